// File: rtl/except_ctrl_pkg.sv
// ============================================================================
// Module   : except_ctrl_pkg
// Brief    : Shared exception codes, CP0 addresses, vectors and FSM encodings.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package except_ctrl_pkg;

  localparam logic [31:0] C_EXC_NONE    = 32'h0000_0000;
  localparam logic [31:0] C_EXC_INT     = 32'h0000_0001;
  localparam logic [31:0] C_EXC_SYSCALL = 32'h0000_0008;
  localparam logic [31:0] C_EXC_INVALID = 32'h0000_000a;
  localparam logic [31:0] C_EXC_TRAP    = 32'h0000_000d;
  localparam logic [31:0] C_EXC_ERET    = 32'h0000_000e;

  localparam logic [31:0] C_EXC_VECTOR  = 32'h0000_0020;

  localparam logic [4:0]  C_CP0_STATUS  = 5'd12;
  localparam logic [4:0]  C_CP0_CAUSE   = 5'd13;
  localparam logic [4:0]  C_CP0_EPC     = 5'd14;

  localparam int          C_RAW_SYSCALL = 8;
  localparam int          C_RAW_INVALID = 9;
  localparam int          C_RAW_TRAP    = 10;
  localparam int          C_RAW_ERET    = 12;

  localparam logic [5:0]  C_STALL_EX    = 6'b001111;
  localparam logic [5:0]  C_STALL_ID    = 6'b000111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/except_ctrl_cp0_fwd.sv
// ============================================================================
// Module   : cp0_fwd
// Brief    : Bypasses an in-flight WB-stage CP0 write onto status/cause/epc.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cp0_fwd
  import except_ctrl_pkg::*;
(
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_reg_we_i,
  input  logic [4:0]  wb_cp0_reg_waddr_i,
  input  logic [31:0] wb_cp0_reg_data_i,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o
);

  always_comb begin
    status_o = cp0_status_i;
    cause_o  = cp0_cause_i;
    epc_o    = cp0_epc_i;
    if (wb_cp0_reg_we_i) begin
      if (wb_cp0_reg_waddr_i == C_CP0_STATUS)
        status_o = wb_cp0_reg_data_i;
      // Only the software-writable cause fields (IP1:0, WP, IV) are bypassed
      if (wb_cp0_reg_waddr_i == C_CP0_CAUSE) begin
        cause_o[9:8] = wb_cp0_reg_data_i[9:8];
        cause_o[22]  = wb_cp0_reg_data_i[22];
        cause_o[23]  = wb_cp0_reg_data_i[23];
      end
      if (wb_cp0_reg_waddr_i == C_CP0_EPC)
        epc_o = wb_cp0_reg_data_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/except_ctrl.sv
// ============================================================================
// Module   : except_ctrl
// Brief    : MEM-stage exception resolution, flush/redirect FSM and stall mux.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module except_ctrl
  import except_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] excepttype_raw_i,
  input  logic [31:0] current_inst_address_i,
  input  logic        is_in_delayslot_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_reg_we_i,
  input  logic [4:0]  wb_cp0_reg_waddr_i,
  input  logic [31:0] wb_cp0_reg_data_i,
  input  logic        stallreq_id_i,
  input  logic        stallreq_ex_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_address_o,
  output logic        is_in_delayslot_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic [5:0]  stall_o
);

  logic [31:0] w_status;
  logic [31:0] w_cause;
  logic [31:0] w_epc;
  logic        w_int_pending;
  logic [31:0] w_exc;
  logic        w_unused_raw;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_drain_cnt;
  logic [1:0]  w_drain_cnt_nxt;
  logic [31:0] r_new_pc;
  logic [31:0] w_new_pc_nxt;

  cp0_fwd u_cp0_fwd (
    .cp0_status_i       (cp0_status_i),
    .cp0_cause_i        (cp0_cause_i),
    .cp0_epc_i          (cp0_epc_i),
    .wb_cp0_reg_we_i    (wb_cp0_reg_we_i),
    .wb_cp0_reg_waddr_i (wb_cp0_reg_waddr_i),
    .wb_cp0_reg_data_i  (wb_cp0_reg_data_i),
    .status_o           (w_status),
    .cause_o            (w_cause),
    .epc_o              (w_epc)
  );

  assign w_int_pending = ((w_cause[15:8] & w_status[15:8]) != 8'h00) &&
                         w_status[0] && !w_status[1];

  assign w_unused_raw = ^{excepttype_raw_i[31:13], excepttype_raw_i[11],
                          excepttype_raw_i[7:0]};

  // Reset gates the code too, so nothing leaks while rst is held
  always_comb begin
    w_exc = C_EXC_NONE;
    if (!rst && r_state == ST_IDLE && current_inst_address_i != 32'h0) begin
      if (w_int_pending)                        w_exc = C_EXC_INT;
      else if (excepttype_raw_i[C_RAW_SYSCALL]) w_exc = C_EXC_SYSCALL;
      else if (excepttype_raw_i[C_RAW_INVALID]) w_exc = C_EXC_INVALID;
      else if (excepttype_raw_i[C_RAW_TRAP])    w_exc = C_EXC_TRAP;
      else if (excepttype_raw_i[C_RAW_ERET])    w_exc = C_EXC_ERET;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_drain_cnt <= 2'd0;
      r_new_pc    <= 32'h0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
      r_new_pc    <= w_new_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_drain_cnt_nxt = r_drain_cnt;
    w_new_pc_nxt    = r_new_pc;
    case (r_state)
      ST_IDLE: begin
        if (w_exc != C_EXC_NONE) begin
          w_state_nxt  = ST_FLUSH;
          w_new_pc_nxt = (w_exc == C_EXC_ERET) ? w_epc : C_EXC_VECTOR;
        end
      end
      ST_FLUSH: begin
        w_state_nxt     = ST_DRAIN;
        w_drain_cnt_nxt = 2'd0;
      end
      ST_DRAIN: begin
        if (r_drain_cnt == 2'd1) begin
          w_state_nxt     = ST_IDLE;
          w_drain_cnt_nxt = 2'd0;
        end else begin
          w_drain_cnt_nxt = r_drain_cnt + 2'd1;
        end
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_drain_cnt_nxt = 2'd0;
      end
    endcase
  end

  // A pending redirect wins over any stall request
  always_comb begin
    stall_o = 6'b000000;
    if (!rst && w_exc == C_EXC_NONE && r_state != ST_FLUSH) begin
      if (stallreq_ex_i)      stall_o = C_STALL_EX;
      else if (stallreq_id_i) stall_o = C_STALL_ID;
    end
  end

  assign excepttype_o           = w_exc;
  assign flush_o                = (r_state == ST_FLUSH);
  assign new_pc_o               = r_new_pc;
  assign current_inst_address_o = current_inst_address_i;
  assign is_in_delayslot_o      = is_in_delayslot_i;

endmodule

`default_nettype wire
